// File: rtl/mul_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: state encoding and default sizing.
package mul_share_arbiter_pkg;

    localparam int unsigned DefaultWidth = 16;
    localparam int unsigned DefaultNreq  = 4;
    localparam int unsigned DefaultIdxw  = 2;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    typedef enum logic [1:0] {
        StIdle   = IDLE,
        StLaunch = LAUNCH,
        StWait   = WAIT,
        StResp   = RESP
    } arb_state_e;

endpackage

// File: rtl/mul_share_arbiter_pick.sv
// Combinational round-robin pick: first set request bit at or above rr_ptr, wrapping at NREQ.
module rr_priority_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDXW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] rr_ptr,
    output logic            found,
    output logic [IDXW-1:0] idx
);

    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [IDXW:0]     sum;

    // Doubling the vector makes the rotation wrap at NREQ rather than at 2^IDXW.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[rr_ptr +: NREQ];

    always_comb begin
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && req_rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, rr_ptr} + (IDXW+1)'(k);
                if (sum >= (IDXW+1)'(NREQ)) begin
                    sum = sum - (IDXW+1)'(NREQ);
                end
                idx = sum[IDXW-1:0];
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sequencer sharing one start/done multiplier among NREQ requesters.
module mul_share_arbiter
    import mul_share_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned NREQ  = DefaultNreq,
    parameter int unsigned IDXW  = DefaultIdxw
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_multiplier,
    input  logic [NREQ*WIDTH-1:0] req_multiplicand,
    output logic [NREQ-1:0]       resp_valid,
    output logic [2*WIDTH-1:0]    resp_product,
    output logic                  busy,
    output logic [IDXW-1:0]       grant_idx,
    output logic                  mul_start,
    output logic [WIDTH-1:0]      mul_multiplier,
    output logic [WIDTH-1:0]      mul_multiplicand,
    input  logic [2*WIDTH-1:0]    mul_product,
    input  logic                  mul_done
);

    arb_state_e         state_q;
    logic [IDXW-1:0]    rr_ptr_q;
    logic [IDXW-1:0]    grant_q;
    logic               seen_low_q;
    logic [2*WIDTH-1:0] result_q;
    logic [NREQ-1:0]    resp_valid_q;
    logic               busy_q;
    logic               mul_start_q;
    logic [WIDTH-1:0]   mul_a_q;
    logic [WIDTH-1:0]   mul_b_q;

    logic               pick_found;
    logic [IDXW-1:0]    pick_idx;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [IDXW-1:0]    rr_ptr_next;

    rr_priority_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_idx == IDXW'(i)) begin
                sel_a = req_multiplier[i*WIDTH +: WIDTH];
                sel_b = req_multiplicand[i*WIDTH +: WIDTH];
            end
        end
    end

    assign rr_ptr_next = (grant_q == IDXW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            seen_low_q   <= 1'b0;
            result_q     <= '0;
            resp_valid_q <= '0;
            busy_q       <= 1'b0;
            mul_start_q  <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        grant_q     <= pick_idx;
                        mul_a_q     <= sel_a;
                        mul_b_q     <= sel_b;
                        mul_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= StLaunch;
                    end
                end
                StLaunch: begin
                    mul_start_q <= 1'b0;
                    seen_low_q  <= 1'b0;
                    state_q     <= StWait;
                end
                StWait: begin
                    // A done level is only trusted after it has been seen low once.
                    if (!mul_done) begin
                        seen_low_q <= 1'b1;
                    end else if (seen_low_q) begin
                        result_q     <= mul_product;
                        resp_valid_q <= NREQ'(1) << grant_q;
                        state_q      <= StResp;
                    end
                end
                StResp: begin
                    resp_valid_q <= '0;
                    rr_ptr_q     <= rr_ptr_next;
                    busy_q       <= 1'b0;
                    state_q      <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign resp_valid       = resp_valid_q;
    assign resp_product     = result_q;
    assign busy             = busy_q;
    assign grant_idx        = grant_q;
    assign mul_start        = mul_start_q;
    assign mul_multiplier   = mul_a_q;
    assign mul_multiplicand = mul_b_q;

endmodule
